// File: rtl/async_fifo_reader.sv
// Read-side consumer of an async FIFO: pops into a 2-entry buffer (main + skid)
// and streams downstream over valid/ready, with a flush mode that discards data.
module async_fifo_reader #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             en,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             busy,
  output logic [CSIZE-1:0] rcount,
  output logic [CSIZE-1:0] dcount
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] buf0_q, buf0_d;
  logic [DSIZE-1:0] buf1_q, buf1_d;
  logic [CSIZE-1:0] rcount_q, rcount_d;
  logic [CSIZE-1:0] dcount_q, dcount_d;
  logic             xfer;
  logic             flush_acc;

  // rinc uses only registered state and rempty, so m_ready never reaches it.
  assign rinc = !rempty && ((state_q == STREAM && occ_q < 2'd2) || state_q == FLUSH);

  assign m_valid   = (state_q != FLUSH) && (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign busy      = (state_q != IDLE) || (occ_q != 2'd0);
  assign rcount    = rcount_q;
  assign dcount    = dcount_q;
  assign xfer      = m_valid && m_ready;
  assign flush_acc = (state_q != FLUSH) && flush;

  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    rcount_d = rcount_q;
    dcount_d = dcount_q;

    case (state_q)
      IDLE:    if (flush) state_d = FLUSH; else if (en) state_d = STREAM;
      STREAM:  if (flush) state_d = FLUSH; else if (!en) state_d = IDLE;
      FLUSH:   if (rempty) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer) rcount_d = rcount_q + 1'b1;

    if (flush_acc) begin
      // Whatever is left after this cycle's transfer, plus this cycle's pop, is dropped.
      dcount_d = dcount_q + CSIZE'(occ_q) - CSIZE'(xfer) + CSIZE'(rinc);
      occ_d    = 2'd0;
    end else if (state_q == FLUSH) begin
      if (rinc) dcount_d = dcount_q + 1'b1;
    end else begin
      case ({rinc, xfer})
        2'b10: begin
          if (occ_q == 2'd0) buf0_d = rdata;
          else               buf1_d = rdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          buf0_d = buf1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11:   buf0_d = rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q  <= IDLE;
      occ_q    <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
      rcount_q <= '0;
      dcount_q <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      rcount_q <= rcount_d;
      dcount_q <= dcount_d;
    end
  end

endmodule

// File: tb/tb_async_fifo_reader.sv
// Directed bench for async_fifo_reader with a queue-based FIFO model on the read side.
module tb_async_fifo_reader;
  localparam int DSIZE = 8;
  localparam int CSIZE = 4;

  logic             rclk = 1'b0;
  logic             rrst = 1'b1;
  logic             rempty = 1'b1;
  logic [DSIZE-1:0] rdata = '0;
  logic             rinc;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DSIZE-1:0] m_data;
  logic             busy;
  logic [CSIZE-1:0] rcount;
  logic [CSIZE-1:0] dcount;

  int total = 0;
  int bad = 0;
  logic [DSIZE-1:0] q[$];

  async_fifo_reader #(.DSIZE(DSIZE), .CSIZE(CSIZE)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .en(en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .rcount(rcount), .dcount(dcount)
  );

  always #5 rclk = ~rclk;

  task automatic fifo_upd();
    rempty = (q.size() == 0);
    rdata  = rempty ? '0 : q[0];
  endtask

  task automatic push(input logic [DSIZE-1:0] v);
    q.push_back(v);
    fifo_upd();
  endtask

  // One clock: sample rinc before the edge, pop the model just after it, end at negedge.
  task automatic cyc();
    logic pre;
    #1;
    pre = rinc;
    @(posedge rclk);
    #1;
    if (pre) void'(q.pop_front());
    fifo_upd();
    @(negedge rclk);
  endtask

  task automatic do_reset();
    rrst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    q.delete();
    fifo_upd();
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL reset_rinc got %b exp 0", rinc); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (rcount !== 4'd0 || dcount !== 4'd0) begin bad++; $display("FAIL reset_counts got r=%0d d=%0d exp 0 0", rcount, dcount); end
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_stream();
    logic [DSIZE-1:0] exp_w[3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    en = 1'b1; m_ready = 1'b1;
    cyc();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stream_latency m_valid got %b exp 0", m_valid); end
    total++; if (rinc !== 1'b1) begin bad++; $display("FAIL stream_rinc_on got %b exp 1", rinc); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i]) begin
        bad++; $display("FAIL stream_word%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp_w[i]);
      end
    end
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL stream_rinc_empty got %b exp 0", rinc); end
    cyc();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stream_drained m_valid got %b exp 0", m_valid); end
    total++; if (rcount !== 4'd3) begin bad++; $display("FAIL stream_rcount got %0d exp 3", rcount); end
  endtask

  task automatic test_backpressure();
    logic [DSIZE-1:0] exp_w[5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    do_reset();
    for (int i = 0; i < 5; i++) push(exp_w[i]);
    en = 1'b1;
    repeat (3) cyc();
    total++; if (m_valid !== 1'b1 || m_data !== 8'hA1) begin bad++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=a1", m_valid, m_data); end
    repeat (2) cyc();
    total++; if (m_data !== 8'hA1) begin bad++; $display("FAIL bp_stable got %h exp a1", m_data); end
    total++; if (q.size() != 3) begin bad++; $display("FAIL bp_pops left %0d exp 3", q.size()); end
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL bp_rinc_full got %b exp 0", rinc); end
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i]) begin
        bad++; $display("FAIL bp_word%0d got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp_w[i]);
      end
      cyc();
    end
    total++; if (rcount !== 4'd5) begin bad++; $display("FAIL bp_rcount got %0d exp 5", rcount); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_end_valid got %b exp 0", m_valid); end
  endtask

  task automatic test_flush();
    int guard;
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hB1 + 8'(i));
    en = 1'b1;
    repeat (4) cyc();
    flush = 1'b1; m_ready = 1'b1;
    cyc();
    flush = 1'b0; en = 1'b0;
    #1;
    total++; if (rcount !== 4'd1) begin bad++; $display("FAIL flush_rcount got %0d exp 1", rcount); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got %b exp 0", m_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy got %b exp 1", busy); end
    total++; if (int'(dcount) + q.size() != 5) begin bad++; $display("FAIL flush_accounting got %0d exp 5", int'(dcount) + q.size()); end
    guard = 0;
    while (q.size() != 0 && guard < 10) begin cyc(); guard++; end
    total++; if (q.size() != 0) begin bad++; $display("FAIL flush_timeout left %0d exp 0", q.size()); end
    total++; if (busy !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL flush_still_busy got b=%b v=%b exp b=1 v=0", busy, m_valid); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle busy got %b exp 0", busy); end
    total++; if (dcount !== 4'd5) begin bad++; $display("FAIL flush_dcount got %0d exp 5", dcount); end
  endtask

  task automatic test_en_drop();
    do_reset();
    for (int i = 0; i < 4; i++) push(8'hC1 + 8'(i));
    en = 1'b1;
    repeat (4) cyc();
    en = 1'b0; m_ready = 1'b1;
    cyc();
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL en_drop_rinc got %b exp 0", rinc); end
    total++; if (m_valid !== 1'b1 || m_data !== 8'hC2) begin bad++; $display("FAIL en_drop_word got v=%b d=%h exp v=1 d=c2", m_valid, m_data); end
    cyc();
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL en_drop_idle got b=%b v=%b exp 0 0", busy, m_valid); end
    total++; if (rcount !== 4'd2 || q.size() != 2) begin bad++; $display("FAIL en_drop_counts got r=%0d left=%0d exp 2 2", rcount, q.size()); end
  endtask

  task automatic test_wrap();
    int n, guard;
    logic [DSIZE-1:0] w;
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i * 3 + 1));
    en = 1'b1; m_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 16 && guard < 40) begin
      #1;
      if (m_valid === 1'b1) begin
        w = 8'(n * 3 + 1);
        total++;
        if (m_data !== w) begin bad++; $display("FAIL wrap_word%0d got %h exp %h", n, m_data, w); end
        n++;
      end
      cyc();
      guard++;
    end
    total++; if (n != 16) begin bad++; $display("FAIL wrap_timeout delivered %0d exp 16", n); end
    total++; if (rcount !== 4'd0) begin bad++; $display("FAIL wrap_rcount got %0d exp 0", rcount); end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 8; i++) push(8'hD1 + 8'(i));
    en = 1'b1; m_ready = 1'b1;
    repeat (3) cyc();
    m_ready = 1'b0;
    repeat (2) cyc();
    total++; if (rcount !== 4'd1 || m_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got r=%0d v=%b exp 1 1", rcount, m_valid); end
    #2 rrst = 1'b1;
    #1;
    total++;
    if (rinc !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 || busy !== 1'b0 || rcount !== 4'd0 || dcount !== 4'd0) begin
      bad++; $display("FAIL midrst_async got rinc=%b v=%b d=%h b=%b r=%0d dc=%0d exp all 0", rinc, m_valid, m_data, busy, rcount, dcount);
    end
    @(posedge rclk);
    @(negedge rclk);
    total++; if (busy !== 1'b0 || rinc !== 1'b0) begin bad++; $display("FAIL midrst_held got b=%b rinc=%b exp 0 0", busy, rinc); end
    en = 1'b0; m_ready = 1'b1;
    rrst = 1'b0;
    cyc();
    total++; if (rinc !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got rinc=%b v=%b b=%b exp 0 0 0", rinc, m_valid, busy); end
  endtask

  initial begin
    fifo_upd();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_en_drop();
    test_wrap();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
